// File: rtl/dbus_sram_responder.sv
// In-order dcache SRAM responder: accepts requests into a DEPTH-entry queue and retires each LATENCY cycles after acceptance.
// Optional random backpressure is enabled by defining DBUS_RESP_STALL_EN.
module dbus_sram_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        dcache_req,
   input  logic        dcache_wr,
   input  logic [3:0]  dcache_wstrb,
   input  logic [2:0]  dcache_size,
   input  logic [31:0] dcache_addr,
   input  logic [31:0] dcache_wdata,
   output logic        dcache_addr_ok,
   output logic        dcache_data_ok,
   output logic [31:0] dcache_rdata,
   output logic        dcache_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [2:0] AGE_MAX = 3'(LATENCY - 1);

   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t                  q [DEPTH];
   logic [DEPTH-1:0][2:0] age;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [31:0]           ram [2**ADDR_W];

   req_t              head, req_in;
   logic              head_ready, head_err, retire, accept;
   logic              acc_block, ret_block;
   logic [ADDR_W-1:0] widx;

`ifdef DBUS_RESP_STALL_EN
   // x^8+x^6+x^5+x^4+1, shifting towards the MSB
   logic [7:0] lfsr;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr <= 8'hA5;
      else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign acc_block = lfsr[0];
   assign ret_block = lfsr[1];
`else
   assign acc_block = 1'b0;
   assign ret_block = 1'b0;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign req_in = '{wr: dcache_wr, wstrb: dcache_wstrb, size: dcache_size,
                     addr: dcache_addr, wdata: dcache_wdata};

   assign head       = q[rd_ptr];
   assign widx       = head.addr[ADDR_W+1:2];
   assign head_ready = (count != '0) && (age[rd_ptr] == AGE_MAX);
   assign retire     = head_ready && !ret_block;
   assign accept     = dcache_req && dcache_addr_ok;

   // A full queue still accepts when the head frees its slot this cycle
   assign dcache_addr_ok = resetn && !acc_block &&
                           ((count < CNT_W'(DEPTH)) || retire);

   assign head_err = (|(head.addr >> (ADDR_W + 2)))
                  || (head.size == 3'd1 && head.addr[0])
                  || (head.size == 3'd2 && head.addr[1:0] != 2'b00)
                  || (head.size > 3'd2)
                  || (head.wr && head.wstrb == 4'h0);

   assign dcache_data_ok = retire;
   assign dcache_err     = retire && head_err;
   assign dcache_rdata   = (retire && !head.wr && !head_err) ? ram[widx] : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         age    <= '0;
      end else begin
         if (accept) wr_ptr <= ptr_inc(wr_ptr);
         if (retire) rd_ptr <= ptr_inc(rd_ptr);
         case ({accept, retire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // Ages saturate at the ready point; free slots just idle there
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && wr_ptr == PTR_W'(i)) age[i] <= 3'd0;
            else if (age[i] != AGE_MAX)        age[i] <= age[i] + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) q[wr_ptr] <= req_in;
   end

   // Writes land on the edge ending their data_ok cycle, so a following read sees them
   always_ff @(posedge clk) begin
      if (retire && head.wr && !head_err) begin
         for (int b = 0; b < 4; b++) begin
            if (head.wstrb[b]) ram[widx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: RAM word-address bits, giving 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..7: cycles from request acceptance to data_ok.
REQ-003 SHALL have parameter DEPTH, default 4, legal range 2..8: maximum outstanding accepted requests.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports dcache_req (in, 1), dcache_wr (in, 1), dcache_wstrb (in, 4), dcache_size (in, 3), dcache_addr (in, 32), dcache_wdata (in, 32): the request channel.
REQ-007 SHALL have port dcache_addr_ok, output, 1 bit: request accepted in any cycle where dcache_req && dcache_addr_ok.
REQ-008 SHALL have port dcache_data_ok, output, 1 bit: one-cycle pulse per completed request.
REQ-009 SHALL have port dcache_rdata, output, 32 bits: read data, valid only while dcache_data_ok is high.
REQ-010 SHALL have port dcache_err, output, 1 bit: the completing request was illegal, valid only while dcache_data_ok is high.

Function
REQ-011 Each accepted request SHALL be captured in full ({wr, wstrb, size, addr, wdata}) into an in-order queue of DEPTH entries.
REQ-012 dcache_addr_ok SHALL be asserted when (occupancy < DEPTH) or the head entry retires in the same cycle; it SHALL NOT depend on dcache_req.
REQ-013 A request accepted at edge T SHALL produce dcache_data_ok in the cycle following edge T+LATENCY-1, provided all older requests have retired; responses SHALL complete strictly in acceptance order, at most one per cycle.
REQ-014 With back-to-back requests and no stall, throughput SHALL be one request per cycle whenever DEPTH >= LATENCY+1.
REQ-015 A request is illegal when: addr[31:ADDR_W+2] is nonzero; or size==1 with addr[0]==1; or size==2 with addr[1:0]!=0; or size>2; or wr==1 with wstrb==0.
REQ-016 An illegal request SHALL complete normally, with dcache_err=1, dcache_rdata=0 and no RAM update.
REQ-017 A legal write SHALL update only the bytes enabled by wstrb, at word addr[ADDR_W+1:2], on the edge ending its data_ok cycle; it SHALL return dcache_rdata=0 and dcache_err=0.
REQ-018 A legal read SHALL return the full 32-bit word at addr[ADDR_W+1:2] in dcache_rdata; byte and halfword extraction is the initiator's job.
REQ-019 The read value SHALL reflect every write accepted before the read, including a write retiring in the immediately preceding cycle.
REQ-020 Every accepted request SHALL be completed even if the initiator later ignores data_ok (initiator-side cancel); the responder has no flush input.
REQ-021 Simultaneous accept and retire on a full queue SHALL leave occupancy unchanged and lose no entry.
REQ-022 Queue pointers SHALL wrap modulo DEPTH.
REQ-023 Occupancy SHALL never exceed DEPTH or go below 0.

Reset
REQ-024 On resetn low, immediately and asynchronously: queue emptied, pointers and age counters cleared, dcache_data_ok=0, dcache_rdata=0, dcache_err=0.
REQ-025 dcache_addr_ok SHALL be 0 while resetn is low, and 1 in the first cycle after release (absent stall).
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Assertion of resetn mid-operation SHALL discard all outstanding requests, with no data_ok for them.

Configuration
REQ-028 Macro DBUS_RESP_STALL_EN SHALL, when defined, add an 8-bit LFSR with polynomial x^8+x^6+x^5+x^4+1 and seed 8'hA5 after reset, advancing every cycle.
REQ-029 With DBUS_RESP_STALL_EN defined, lfsr[0]==1 SHALL force dcache_addr_ok low, and lfsr[1]==1 SHALL hold off a ready head entry for that cycle. Ordering, data and error results SHALL be unchanged.
REQ-030 Without DBUS_RESP_STALL_EN, no LFSR SHALL exist, and timing SHALL be exactly per REQ-012/REQ-013.

Verification
REQ-031 Write wr=1, wstrb=4'hf, size=2, addr=0x10, wdata=0xDEADBEEF, then read addr=0x10 -> two data_ok pulses; the read returns 0xDEADBEEF with err=0.
REQ-032 Write wstrb=4'h4, wdata=0x00AA0000 to 0x10 (holding 0xDEADBEEF), then read 0x10 -> rdata=0xDEAABEEF.
REQ-033 Six back-to-back reads with LATENCY=2, DEPTH=4 -> addr_ok never drops, six data_ok pulses on consecutive cycles, first pulse 2 cycles after first accept, in order.
REQ-034 Read size=2 at addr=0x13; then read addr=0x0000_1000 with ADDR_W=10 -> each gets data_ok with err=1 and rdata=0; RAM unchanged.
REQ-035 Fill DEPTH=4 with LATENCY=7 -> addr_ok=0 once 4 are outstanding; addr_ok returns to 1 in the head's retire cycle, and an accept in that cycle keeps occupancy at 4.
REQ-036 Drop resetn with 3 requests outstanding -> no further data_ok, outputs zero; after release addr_ok=1 and a new read completes in LATENCY cycles.
